cnn_pool_stage: RTL and testbench

- Streaming 2x2, stride-2 max-pool stage directly downstream of the cnn convolution core.
- Consumes output feature-map words one per handshake, in raster order: map m, then row r, then column c.
- Emits pooled words in the same raster order with valid/ready backpressure, followed by an optional ReLU.
- Words are IEEE-754 single-precision bit patterns, i.e. $shortrealtobits of the cnn shortreal fm_o.

---
 rtl/cnn_pool_stage_if.sv | 21 ++
 rtl/cnn_pool_stage.sv | 145 ++++++++++++++
 tb/tb_cnn_pool_stage.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pool_stage_if.sv
// Handshake bundle between the pooling stage (slave) and its environment (master).
interface cnn_pool_stage_if;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic        done_o;
    logic        start_i;

    modport master (
        output valid_i, data_i, ready_i, start_i,
        input  ready_o, valid_o, data_o, done_o
    );

    modport slave (
        input  valid_i, data_i, ready_i, start_i,
        output ready_o, valid_o, data_o, done_o
    );
endinterface

// File: rtl/cnn_pool_stage.sv
// Streaming 2x2 stride-2 fp32 max-pool with a single valid/ready output register.
// Optional ReLU on the pooled result is enabled by defining CNN_POOL_RELU_EN.
module cnn_pool_stage #(
    parameter int M_p = 4,
    parameter int R_p = 16,
    parameter int C_p = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    cnn_pool_stage_if.slave bus
);
    localparam int C_W  = (C_p > 1) ? $clog2(C_p) : 1;
    localparam int R_W  = (R_p > 1) ? $clog2(R_p) : 1;
    localparam int M_W  = (M_p > 1) ? $clog2(M_p) : 1;
    localparam int LB_D = C_p / 2;
    localparam int LB_W = (LB_D > 1) ? $clog2(LB_D) : 1;

    typedef enum logic [1:0] {eRUN, eDRAIN, eDONE} state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [C_W-1:0]  r_col;
    logic [R_W-1:0]  r_row;
    logic [M_W-1:0]  r_map;
    logic [31:0]     r_pair;
    logic [31:0]     r_lb [LB_D];
    logic            r_valid;
    logic [31:0]     r_data;

    logic            w_ready;
    logic            w_done;
    logic            w_accept;
    logic            w_load;
    logic            w_lbWrite;
    logic            w_colLast;
    logic            w_rowLast;
    logic            w_mapLast;
    logic            w_lastWord;
    logic            w_restart;
    logic [LB_W-1:0] w_lbIdx;
    logic [31:0]     w_pairMax;
    logic [31:0]     w_poolMax;
    logic [31:0]     w_result;

    // Bit-pattern max; the first operand wins ties so the earlier word is kept.
    function automatic logic [31:0] fpMax(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return a[31] ? b : a;
        else if (!a[31])
            return (b[30:0] > a[30:0]) ? b : a;
        else
            return (b[30:0] < a[30:0]) ? b : a;
    endfunction

    assign w_accept   = bus.valid_i && w_ready;
    assign w_colLast  = (r_col == C_W'(C_p - 1));
    assign w_rowLast  = (r_row == R_W'(R_p - 1));
    assign w_mapLast  = (r_map == M_W'(M_p - 1));
    assign w_lastWord = w_colLast && w_rowLast && w_mapLast;
    assign w_restart  = (r_state == eDONE) && bus.start_i;
    assign w_lbIdx    = LB_W'(r_col >> 1);
    assign w_pairMax  = fpMax(r_pair, bus.data_i);
    assign w_poolMax  = fpMax(r_lb[w_lbIdx], w_pairMax);
    assign w_lbWrite  = w_accept && !r_row[0] && r_col[0];
    assign w_load     = w_accept && r_row[0] && r_col[0];

`ifdef CNN_POOL_RELU_EN
    assign w_result = w_poolMax[31] ? 32'h0000_0000 : w_poolMax;
`else
    assign w_result = w_poolMax;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i)
            r_state <= eRUN;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            eRUN:    if (w_accept && w_lastWord) w_nextState = eDRAIN;
            eDRAIN:  if (!r_valid || bus.ready_i) w_nextState = eDONE;
            eDONE:   if (bus.start_i) w_nextState = eRUN;
            default: w_nextState = eRUN;
        endcase
    end

    always_comb begin
        w_ready = (r_state == eRUN) && (!r_valid || bus.ready_i);
        w_done  = (r_state == eDONE);
    end

    // Raster counters: column fastest, then row, then map.
    always_ff @(posedge clk_i) begin
        if (reset_i || w_restart) begin
            r_col <= '0;
            r_row <= '0;
            r_map <= '0;
        end else if (w_accept) begin
            if (w_colLast) begin
                r_col <= '0;
                if (w_rowLast) begin
                    r_row <= '0;
                    r_map <= w_mapLast ? '0 : r_map + M_W'(1);
                end else begin
                    r_row <= r_row + R_W'(1);
                end
            end else begin
                r_col <= r_col + C_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            r_pair <= '0;
        else if (w_accept && !r_col[0])
            r_pair <= bus.data_i;
    end

    // Even rows fill the line buffer and odd rows only read it, so the two never collide.
    always_ff @(posedge clk_i) begin
        if (w_lbWrite)
            r_lb[w_lbIdx] <= w_pairMax;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_result;
        end else if (bus.ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.ready_o = w_ready;
    assign bus.valid_o = r_valid;
    assign bus.data_o  = r_data;
    assign bus.done_o  = w_done;
endmodule

// File: tb/tb_cnn_pool_stage.sv
// Self-checking bench for cnn_pool_stage: single-window vectors on a 1x2x2 instance,
// ramp streams with backpressure, mid-stream reset and restart on the default instance.
module tb_cnn_pool_stage;
    logic clk = 1'b0;
    logic resetSmall = 1'b1;
    logic resetBig = 1'b1;
    bit   bpEnable = 1'b0;
    int   bpCycle = 0;
    int   testsRun = 0;
    int   testsFailed = 0;
    logic [31:0] expQ [$];
    bit   prevStall = 1'b0;
    logic [31:0] prevData = '0;

    typedef struct packed {
        logic [3:0][31:0] din;
        logic [31:0]      expOut;
    } windowVec_t;

    windowVec_t vecs [6];

    cnn_pool_stage_if smallBus();
    cnn_pool_stage_if bigBus();

    cnn_pool_stage #(.M_p(1), .R_p(2), .C_p(2)) dutSmall (
        .clk_i(clk), .reset_i(resetSmall), .bus(smallBus)
    );

    cnn_pool_stage #(.M_p(4), .R_p(16), .C_p(16)) dutBig (
        .clk_i(clk), .reset_i(resetBig), .bus(bigBus)
    );

    always #5 clk = ~clk;

    // Expected results go through the same optional ReLU the build selects.
    function automatic logic [31:0] reluModel(input logic [31:0] x);
`ifdef CNN_POOL_RELU_EN
        return x[31] ? 32'h0000_0000 : x;
`else
        return x;
`endif
    endfunction

    // Exact fp32 encoding of a non-negative integer below 2^24.
    function automatic logic [31:0] intToFp(input int n);
        int e;
        logic [31:0] mant;
        if (n == 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 24; i++) if (n[i]) e = i;
        mant = 32'(n) << (23 - e);
        return {1'b0, 8'(127 + e), mant[22:0]};
    endfunction

    function automatic windowVec_t mkVec(input logic [31:0] w0, input logic [31:0] w1,
                                         input logic [31:0] w2, input logic [31:0] w3,
                                         input logic [31:0] e);
        windowVec_t v;
        v.din[0] = w0;
        v.din[1] = w1;
        v.din[2] = w2;
        v.din[3] = w3;
        v.expOut = e;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic sendSmall(input logic [31:0] word);
        bit accepted = 1'b0;
        smallBus.valid_i = 1'b1;
        smallBus.data_i  = word;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (smallBus.ready_o) begin
                @(posedge clk);
                #1;
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) checkOutput("small accept timeout", 32'd0, 32'd1);
    endtask

    task automatic sendBig(input logic [31:0] word);
        bit accepted = 1'b0;
        bigBus.valid_i = 1'b1;
        bigBus.data_i  = word;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bigBus.ready_o) begin
                @(posedge clk);
                #1;
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) checkOutput("big accept timeout", 32'd0, 32'd1);
    endtask

    // One full 1x2x2 stream: single output one cycle after the last accept, then done, then restart.
    task automatic applyStimulus(input windowVec_t v, input bit pulseStart);
        for (int i = 0; i < 4; i++) begin
            sendSmall(v.din[i]);
            if (pulseStart && i == 1) begin
                smallBus.valid_i = 1'b0;
                smallBus.start_i = 1'b1;
                @(posedge clk);
                #1;
                smallBus.start_i = 1'b0;
            end
        end
        smallBus.valid_i = 1'b0;
        checkOutput("small valid_o after last accept", 32'(smallBus.valid_o), 32'd1);
        checkOutput("small data_o", smallBus.data_o, reluModel(v.expOut));
        checkOutput("small ready_o in drain", 32'(smallBus.ready_o), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("small done_o", 32'(smallBus.done_o), 32'd1);
        checkOutput("small valid_o drained", 32'(smallBus.valid_o), 32'd0);
        smallBus.start_i = 1'b1;
        @(posedge clk);
        #1;
        smallBus.start_i = 1'b0;
        checkOutput("small done_o after start", 32'(smallBus.done_o), 32'd0);
        checkOutput("small ready_o after start", 32'(smallBus.ready_o), 32'd1);
    endtask

    task automatic runRamp(input int nWords);
        for (int idx = 0; idx < nWords; idx++) sendBig(intToFp(idx));
        bigBus.valid_i = 1'b0;
    endtask

    task automatic pushRampExpected(input int nMaps);
        for (int m = 0; m < nMaps; m++)
            for (int pr = 0; pr < 8; pr++)
                for (int pc = 0; pc < 8; pc++)
                    expQ.push_back(reluModel(intToFp(m * 256 + (2 * pr + 1) * 16 + 2 * pc + 1)));
    endtask

    task automatic waitDone(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bigBus.done_o) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, 32'(seen), 32'd1);
        checkOutput("scoreboard drained at done", 32'(expQ.size()), 32'd0);
    endtask

    // Downstream ready: periodic 5-cycle stalls when backpressure is enabled.
    always @(posedge clk) begin
        #1;
        bpCycle = bpCycle + 1;
        bigBus.ready_i = !bpEnable || ((bpCycle % 23) >= 5);
    end

    // Output monitor for the default instance: scoreboard and stall stability.
    always @(negedge clk) begin
        if (!resetBig) begin
            if (prevStall) begin
                checkOutput("stall keeps valid_o", 32'(bigBus.valid_o), 32'd1);
                checkOutput("stall keeps data_o", bigBus.data_o, prevData);
            end
            if (bigBus.valid_o && !bigBus.ready_i)
                checkOutput("ready_o low while stalled", 32'(bigBus.ready_o), 32'd0);
            if (bigBus.valid_o && bigBus.ready_i) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected output: got %h, scoreboard empty", bigBus.data_o);
                end else begin
                    checkOutput("pooled word", bigBus.data_o, expQ.pop_front());
                end
            end
            prevStall = bigBus.valid_o && !bigBus.ready_i;
            prevData  = bigBus.data_o;
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = mkVec(32'h3F800000, 32'h40400000, 32'h40000000, 32'hC0A00000, 32'h40400000);
        vecs[1] = mkVec(32'hBF800000, 32'hC0000000, 32'hBF000000, 32'hC0800000, 32'hBF000000);
        vecs[2] = mkVec(32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000);
        vecs[3] = mkVec(32'h7F800000, 32'h7FC00000, 32'h3F800000, 32'hFF800000, 32'h7FC00000);
        vecs[4] = mkVec(32'h3F800000, 32'h3F800000, 32'hC0000000, 32'hC0400000, 32'h3F800000);
        vecs[5] = mkVec(32'hFFC00000, 32'hFF800000, 32'hBF800000, 32'hFFFFFFFF, 32'hBF800000);

        smallBus.valid_i = 1'b0;
        smallBus.data_i  = '0;
        smallBus.ready_i = 1'b1;
        smallBus.start_i = 1'b0;
        bigBus.valid_i   = 1'b0;
        bigBus.data_i    = '0;
        bigBus.start_i   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        resetSmall = 1'b0;
        resetBig   = 1'b0;

        checkOutput("reset valid_o", 32'(smallBus.valid_o), 32'd0);
        checkOutput("reset data_o", smallBus.data_o, 32'd0);
        checkOutput("reset done_o", 32'(smallBus.done_o), 32'd0);
        checkOutput("reset ready_o", 32'(smallBus.ready_o), 32'd1);
        checkOutput("reset big valid_o", 32'(bigBus.valid_o), 32'd0);
        checkOutput("reset big done_o", 32'(bigBus.done_o), 32'd0);

        // A start pulse in the middle of a stream must not disturb the counters.
        applyStimulus(vecs[0], 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], 1'b0);

        // Partial stream of 37 words, then reset; only row pairs 0/1 of map 0 produce outputs.
        for (int pc = 0; pc < 8; pc++) expQ.push_back(reluModel(intToFp(16 + 2 * pc + 1)));
        runRamp(37);
        repeat (3) @(posedge clk);
        #1;
        resetBig = 1'b1;
        @(posedge clk);
        #1;
        resetBig = 1'b0;
        checkOutput("valid_o after mid reset", 32'(bigBus.valid_o), 32'd0);
        checkOutput("ready_o after mid reset", 32'(bigBus.ready_o), 32'd1);
        checkOutput("done_o after mid reset", 32'(bigBus.done_o), 32'd0);
        checkOutput("partial stream outputs seen", 32'(expQ.size()), 32'd0);

        // Fresh full stream under periodic backpressure.
        pushRampExpected(4);
        bpEnable = 1'b1;
        runRamp(1024);
        waitDone("done_o after first stream");
        bpEnable = 1'b0;
        checkOutput("ready_o in done", 32'(bigBus.ready_o), 32'd0);

        @(posedge clk);
        #1;
        bigBus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bigBus.start_i = 1'b0;
        checkOutput("big done_o after start", 32'(bigBus.done_o), 32'd0);
        checkOutput("big ready_o after start", 32'(bigBus.ready_o), 32'd1);

        pushRampExpected(4);
        runRamp(1024);
        waitDone("done_o after second stream");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
